keystream_arbiter: RTL

//  Round-robin arbiter sharing one hash_generator keystream-byte source among NUM_REQ

---
 rtl/keystream_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/keystream_arbiter.sv
// Round-robin arbiter sharing one keystream-byte generator among requesters.
// Sequences rekeys so the generator is only reset while idle.
module keystream_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               rekey_req,
  input  logic [7:0]         gen_byte,
  input  logic               gen_byte_pulse,
  output logic               gen_request,
  output logic               gen_reset,
  output logic [7:0]         byte_out,
  output logic [NUM_REQ-1:0] ack,
  output logic               rekey_ack,
  output logic               busy,
  output logic               timeout_err
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DELIVER,
    REKEY
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        gnt_q, gnt_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic                 pend_q, pend_d;
  logic [7:0]           byte_q, byte_d;
  logic                 terr_q, terr_d;
  logic                 greq_q, grst_q;
  logic                 rkack_q, busy_q;
  logic [NUM_REQ-1:0]   ack_q, ack_d;

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic                 found;
  logic [PW-1:0]        pick;
  logic [PW-1:0]        nxt;
  logic [TW-1:0]        tcnt_inc;
  int                   sum;

  // Rotate requests so bit 0 is the rr_ptr position, then take the first set.
  assign dbl = {req, req};

  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = 0;
    rot   = dbl[{1'b0, rr_q} +: NUM_REQ];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = int'(rr_q) + i;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        pick  = PW'(sum);
      end
    end
  end

  assign nxt = (gnt_q == PW'(NUM_REQ - 1)) ? '0 : gnt_q + PW'(1);
  assign tcnt_inc = (&tcnt_q) ? tcnt_q : tcnt_q + TW'(1);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    tcnt_d  = tcnt_q;
    pend_d  = pend_q | (rekey_req && state_q != IDLE);
    byte_d  = byte_q;
    terr_d  = terr_q;
    unique case (state_q)
      IDLE: begin
        if (pend_q || rekey_req) begin
          state_d = REKEY;
        end else if (found) begin
          gnt_d   = pick;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (gen_byte_pulse) begin
          byte_d  = gen_byte;
          state_d = DELIVER;
        end else begin
          tcnt_d = tcnt_inc;
          if (tcnt_inc == TW'(TIMEOUT_CYCLES)) begin
            terr_d  = 1'b1;
            rr_d    = nxt;
            state_d = IDLE;
          end
        end
      end
      DELIVER: begin
        rr_d    = nxt;
        state_d = IDLE;
      end
      REKEY: begin
        pend_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d = '0;
    if (state_d == DELIVER) ack_d = NUM_REQ'(1) << gnt_d;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      tcnt_q  <= '0;
      pend_q  <= 1'b0;
      byte_q  <= '0;
      terr_q  <= 1'b0;
      greq_q  <= 1'b0;
      grst_q  <= 1'b0;
      rkack_q <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      tcnt_q  <= tcnt_d;
      pend_q  <= pend_d;
      byte_q  <= byte_d;
      terr_q  <= terr_d;
      greq_q  <= (state_d == ISSUE);
      grst_q  <= (state_d == REKEY);
      rkack_q <= (state_d == REKEY);
      busy_q  <= (state_d != IDLE) | pend_d;
      ack_q   <= ack_d;
    end
  end

  assign gen_request = greq_q;
  assign gen_reset   = grst_q;
  assign byte_out    = byte_q;
  assign ack         = ack_q;
  assign rekey_ack   = rkack_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

`ifndef SYNTHESIS
  a_ack_onehot : assert property (
    @(posedge clk) disable iff (!nrst) $onehot0(ack));
  a_req_rst_excl : assert property (
    @(posedge clk) disable iff (!nrst) !(gen_request && gen_reset));
  a_req_in_issue : assert property (
    @(posedge clk) disable iff (!nrst) gen_request |-> state_q == ISSUE);
`endif

endmodule
